// File: rtl/greensc_ctrl_if.sv
// rtl/greensc_ctrl_if.sv - pixel stream bundle (frame sync, pixel valid, RGB) for the keyer
interface greensc_ctrl_if;
  logic       vs;
  logic       de;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output vs, de, r, g, b);
  modport slave  (input  vs, de, r, g, b);
endinterface

// File: rtl/greensc_ctrl.sv
// rtl/greensc_ctrl.sv - green-screen keyer controller: frame-synced config, 2-stage keying pipe, keyed-pixel count
module greensc_ctrl #(
  parameter int          CNTW       = 20,
  parameter logic [24:0] THRESH_RST = 25'h0143DA,
  parameter logic        EN_RST     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  greensc_ctrl_if.slave    pix_in,
  greensc_ctrl_if.master   pix_out,
  input  logic [24:0]      cfg_thresh,
  input  logic             cfg_en,
  input  logic             cfg_wr,
  output logic [24:0]      act_thresh,
  output logic             act_en,
  output logic [CNTW-1:0]  key_count,
  output logic             count_valid,
  output logic             running
);

  typedef enum logic {ST_WAIT, ST_RUN} state_t;

  localparam logic [CNTW-1:0] CNT_ONE = 1;

  state_t            state, state_nxt;
  logic              vs_q;
  logic              fs;
  logic [24:0]       pend_thresh;
  logic              pend_en;

  logic [7:0]        r1, g1, b1;
  logic              de1, vs1;
  logic signed [17:0] p1;
  logic signed [8:0]  db1;

  logic signed [8:0]  g_s, dr_c, db_c;
  logic signed [26:0] gr, thr_s;
  logic              key, key_hit;
  logic [CNTW-1:0]   cnt, cnt_inc;

  assign fs      = pix_in.vs & ~vs_q;
  assign running = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
      vs_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      vs_q  <= pix_in.vs;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_WAIT && fs)
      state_nxt = ST_RUN;
  end

  // A write landing on the frame-start cycle bypasses the pending regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_thresh <= THRESH_RST;
      pend_en     <= EN_RST;
      act_thresh  <= THRESH_RST;
      act_en      <= EN_RST;
    end else begin
      if (cfg_wr) begin
        pend_thresh <= cfg_thresh;
        pend_en     <= cfg_en;
      end
      if (fs) begin
        act_thresh <= cfg_wr ? cfg_thresh : pend_thresh;
        act_en     <= cfg_wr ? cfg_en     : pend_en;
      end
    end
  end

  assign g_s  = $signed({1'b0, pix_in.g});
  assign dr_c = g_s - $signed({1'b0, pix_in.r});
  assign db_c = g_s - $signed({1'b0, pix_in.b});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
      p1  <= '0;
      db1 <= '0;
      de1 <= 1'b0;
      vs1 <= 1'b0;
    end else begin
      de1 <= pix_in.de;
      vs1 <= pix_in.vs;
      if (pix_in.de) begin
        r1  <= pix_in.r;
        g1  <= pix_in.g;
        b1  <= pix_in.b;
        p1  <= 18'(g_s) * 18'(dr_c);
        db1 <= db_c;
      end
    end
  end

  assign gr      = 27'(p1) * 27'(db1);
  assign thr_s   = $signed({2'b00, act_thresh});
  assign key     = act_en & (gr > thr_s);
  assign key_hit = de1 & key;
  assign cnt_inc = (key_hit && cnt != '1) ? cnt + CNT_ONE : cnt;

  // The pixel sitting in S2 on the frame-start cycle still belongs to the closing frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      key_count   <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (state == ST_RUN) begin
        if (fs) begin
          key_count   <= cnt_inc;
          count_valid <= 1'b1;
          cnt         <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out.vs <= 1'b0;
      pix_out.de <= 1'b0;
      pix_out.r  <= '0;
      pix_out.g  <= '0;
      pix_out.b  <= '0;
    end else begin
      pix_out.vs <= vs1;
      pix_out.de <= de1 & running;
      if (de1) begin
        pix_out.r <= key ? 8'd0 : r1;
        pix_out.g <= key ? 8'd0 : g1;
        pix_out.b <= key ? 8'd0 : b1;
      end
    end
  end

endmodule

// File: tb/tb_greensc_ctrl.sv
// tb/tb_greensc_ctrl.sv - randomized bench for greensc_ctrl against a frame-level keyer reference model
module tb_greensc_ctrl;

  localparam int THR_RST = 82906;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  greensc_ctrl_if pin();
  greensc_ctrl_if pout();
  greensc_ctrl_if pout4();

  logic [24:0] cfg_thresh;
  logic        cfg_en, cfg_wr;
  logic [24:0] act_thresh, act_thresh4;
  logic        act_en, act_en4;
  logic [19:0] key_count;
  logic [3:0]  key_count4;
  logic        count_valid, count_valid4, running, running4;

  greensc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pin), .pix_out(pout),
    .cfg_thresh(cfg_thresh), .cfg_en(cfg_en), .cfg_wr(cfg_wr),
    .act_thresh(act_thresh), .act_en(act_en), .key_count(key_count),
    .count_valid(count_valid), .running(running)
  );

  greensc_ctrl #(.CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pix_in(pin), .pix_out(pout4),
    .cfg_thresh(cfg_thresh), .cfg_en(cfg_en), .cfg_wr(cfg_wr),
    .act_thresh(act_thresh4), .act_en(act_en4), .key_count(key_count4),
    .count_valid(count_valid4), .running(running4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: frame-level view of config, counting and a 2-deep pixel delay.
  int m_prev_vs, m_run, m_pth, m_pen, m_ath, m_aen;
  int m_cnt, m_kc, m_cv, m_cnt4, m_kc4;
  int m_s1_de, m_s1_vs, m_s1_r, m_s1_g, m_s1_b;
  int m_ode, m_ovs, m_or, m_og, m_ob;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int greenness(input int r, input int g, input int b);
    return g * (g - r) * (g - b);
  endfunction

  task automatic model_reset();
    m_prev_vs = 0; m_run = 0;
    m_pth = THR_RST; m_pen = 1; m_ath = THR_RST; m_aen = 1;
    m_cnt = 0; m_kc = 0; m_cv = 0; m_cnt4 = 0; m_kc4 = 0;
    m_s1_de = 0; m_s1_vs = 0; m_s1_r = 0; m_s1_g = 0; m_s1_b = 0;
    m_ode = 0; m_ovs = 0; m_or = 0; m_og = 0; m_ob = 0;
  endtask

  task automatic model_step();
    int fs, hit, c, c4;
    fs  = (pin.vs && !m_prev_vs) ? 1 : 0;
    hit = (m_s1_de && m_aen && greenness(m_s1_r, m_s1_g, m_s1_b) > m_ath) ? 1 : 0;
    m_ode = (m_s1_de && m_run) ? 1 : 0;
    m_ovs = m_s1_vs;
    if (m_s1_de) begin
      m_or = hit ? 0 : m_s1_r;
      m_og = hit ? 0 : m_s1_g;
      m_ob = hit ? 0 : m_s1_b;
    end
    m_cv = 0;
    if (m_run) begin
      c  = m_cnt + hit;  if (c > 20'hFFFFF) c = 20'hFFFFF;
      c4 = m_cnt4 + hit; if (c4 > 15) c4 = 15;
      if (fs) begin
        m_kc = c; m_kc4 = c4; m_cv = 1; m_cnt = 0; m_cnt4 = 0;
      end else begin
        m_cnt = c; m_cnt4 = c4;
      end
    end
    if (fs) begin
      m_ath = cfg_wr ? int'(cfg_thresh) : m_pth;
      m_aen = cfg_wr ? int'(cfg_en) : m_pen;
      m_run = 1;
    end
    if (cfg_wr) begin
      m_pth = cfg_thresh;
      m_pen = cfg_en;
    end
    m_prev_vs = pin.vs;
    m_s1_de = pin.de;
    m_s1_vs = pin.vs;
    if (pin.de) begin
      m_s1_r = pin.r; m_s1_g = pin.g; m_s1_b = pin.b;
    end
  endtask

  task automatic check_all();
    check("out_vs", pout.vs, m_ovs);
    check("out_de", pout.de, m_ode);
    check("out_r", pout.r, m_or);
    check("out_g", pout.g, m_og);
    check("out_b", pout.b, m_ob);
    check("act_thresh", act_thresh, m_ath);
    check("act_en", act_en, m_aen);
    check("key_count", key_count, m_kc);
    check("count_valid", count_valid, m_cv);
    check("running", running, m_run);
    check("key_count4", key_count4, m_kc4);
    check("count_valid4", count_valid4, m_cv);
  endtask

  task automatic cyc(input logic vs, input logic de, input int r, input int g, input int b);
    pin.vs = vs; pin.de = de;
    pin.r = 8'(r); pin.g = 8'(g); pin.b = 8'(b);
    @(posedge clk);
    #1 model_step();
    @(negedge clk);
    check_all();
    cfg_wr = 1'b0;
  endtask

  task automatic set_cfg(input int th, input logic en);
    cfg_thresh = 25'(th);
    cfg_en = en;
    cfg_wr = 1'b1;
  endtask

  task automatic rand_pix(output int r, output int g, output int b);
    case ($urandom_range(0, 4))
      0: begin r = 0;   g = 255; b = 0;   end
      1: begin r = 40;  g = 200; b = 40;  end
      2: begin r = 200; g = 200; b = 200; end
      3: begin r = 255; g = 0;   b = 0;   end
      default: begin r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255); end
    endcase
  endtask

  // Random de gaps go before each pixel so a frame's last pixel sits right before the next vs.
  task automatic rand_frame(input int npix);
    int r, g, b;
    for (int i = 0; i < npix; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, $urandom_range(0, 255), 0, 0);
      rand_pix(r, g, b);
      cyc(1'b0, 1'b1, r, g, b);
    end
  endtask

  task automatic vs_pulse();
    cyc(1'b1, 1'b0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    pin.vs = 1'b0; pin.de = 1'b0; cfg_wr = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    pin.vs = 1'b0; pin.de = 1'b0; pin.r = 8'd0; pin.g = 8'd0; pin.b = 8'd0;
    cfg_thresh = 25'd0; cfg_en = 1'b0; cfg_wr = 1'b0;
    @(negedge clk);
    do_reset();

    // Green before any frame start: gated, not counted.
    repeat (4) cyc(1'b0, 1'b1, 0, 255, 0);
    check("wait_de", pout.de, 0);
    cyc(1'b1, 1'b1, 0, 255, 0);
    cyc(1'b1, 1'b1, 0, 255, 0);
    check("first_fs_run", running, 1);
    check("first_key_out", {pout.de, pout.r, pout.g, pout.b}, {1'b1, 24'd0});
    cyc(1'b0, 1'b1, 40, 200, 40);
    cyc(1'b0, 1'b1, 200, 200, 200);
    cyc(1'b0, 1'b1, 255, 0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0);
    rand_frame(20);

    // Mid-frame threshold write only lands at the next frame start.
    set_cfg(25'h1FFFFFF, 1'b1);
    cyc(1'b0, 1'b1, 0, 255, 0);
    repeat (5) cyc(1'b0, 1'b1, 0, 255, 0);
    check("midframe_thr", act_thresh, THR_RST);
    vs_pulse();
    check("new_thr", act_thresh, 25'h1FFFFFF);
    repeat (6) cyc(1'b0, 1'b1, 0, 255, 0);
    set_cfg(THR_RST, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 0);
    vs_pulse();

    // 100 pixels, 37 keyed, the last one lands in S2 on the fs cycle.
    for (int i = 0; i < 100; i++) begin
      if (i > 0 && $urandom_range(0, 4) == 0) cyc(1'b0, 1'b0, 0, 255, 0);
      if ((i < 72 && i % 2 == 0) || i == 99) cyc(1'b0, 1'b1, 0, 255, 0);
      else if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b1, 200, 200, 200);
      else cyc(1'b0, 1'b1, 255, 0, 0);
    end
    set_cfg(THR_RST, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    check("count37", key_count, 37);
    check("count_sat4", key_count4, 15);
    check("bypass_en", act_en, 0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0);
    rand_frame(40);
    set_cfg(THR_RST, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 0);
    vs_pulse();
    check("count_disabled", key_count, 0);

    // Random frames with random config traffic, including writes on the fs cycle.
    for (int f = 0; f < 8; f++) begin
      int th;
      case ($urandom_range(0, 3))
        0: th = THR_RST;
        1: th = 0;
        2: th = $urandom_range(0, 16777215);
        default: th = 25'h1FFFFFF;
      endcase
      if ($urandom_range(0, 1) == 1) set_cfg(th, ($urandom_range(0, 3) != 0));
      cyc(1'b1, 1'b0, 0, 0, 0);
      cyc(1'b0, 1'b1, 0, 255, 0);
      if ($urandom_range(0, 1) == 1) set_cfg($urandom_range(0, 5000000), 1'b1);
      rand_frame($urandom_range(10, 60));
      if ($urandom_range(0, 1) == 1) set_cfg(THR_RST, 1'b1);
      cyc(1'b0, 1'b1, 0, 255, 0);
    end

    // Reset in the middle of a frame, then resume.
    vs_pulse();
    rand_frame(15);
    do_reset();
    repeat (3) cyc(1'b0, 1'b1, 0, 255, 0);
    vs_pulse();
    check("reset_no_pulse", count_valid, 0);
    rand_frame(30);
    vs_pulse();
    rand_frame(20);
    cyc(1'b1, 1'b0, 0, 0, 0);
    check("final_pulse", count_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
